// File: rtl/regfile_mp_sb_if.sv
// Bundle of read, writeback, issue and flush signals between the pipeline and regfile_mp_sb.
// The master side is the pipeline; the slave side is the register file.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_rd;
    logic                     flush;
    logic [(1<<ADDR_W)-1:0]   busy_vec;

    modport master (
        output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_valid, iss_rd, flush,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_valid, iss_rd, flush,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two writeback ports, write-to-read bypass and
// a per-register pending (scoreboard) bit for RAW hazard detection at issue.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]         r_busy;
    logic [DEPTH-1:0]         w_busy_nxt;
    logic                     w_eff0;
    logic                     w_eff1;
    logic [NUM_RD*DATA_W-1:0] w_rdata;
    logic [NUM_RD-1:0]        w_rbusy;

    // A write to x0 is discarded entirely when register 0 is hardwired.
    assign w_eff0 = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == {ADDR_W{1'b0}}));
    assign w_eff1 = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == {ADDR_W{1'b0}}));

    // Read ports: zero register, then port 1 bypass, then port 0 bypass, then array.
    always_comb begin
        w_rdata = '0;
        w_rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic              hit0;
            logic              hit1;
            ra   = bus.raddr[i*ADDR_W +: ADDR_W];
            hit0 = w_eff0 && (bus.waddr0 == ra);
            hit1 = w_eff1 && (bus.waddr1 == ra);
            if ((ZERO_REG != 0) && (ra == {ADDR_W{1'b0}})) begin
                w_rdata[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                w_rbusy[i]                  = 1'b0;
            end else begin
                if (hit1) begin
                    w_rdata[i*DATA_W +: DATA_W] = bus.wdata1;
                end else if (hit0) begin
                    w_rdata[i*DATA_W +: DATA_W] = bus.wdata0;
                end else begin
                    w_rdata[i*DATA_W +: DATA_W] = r_mem[ra];
                end
                w_rbusy[i] = r_busy[ra] && !(hit0 || hit1);
            end
        end
    end

    assign bus.rdata    = w_rdata;
    assign bus.rbusy    = w_rbusy;
    assign bus.busy_vec = r_busy;

    // Scoreboard next state: the issue set is applied last so a new producer wins over a retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.flush) begin
            w_busy_nxt = {DEPTH{1'b0}};
        end else begin
            if (w_eff0) begin
                w_busy_nxt[bus.waddr0] = 1'b0;
            end else begin
                w_busy_nxt = w_busy_nxt;
            end
            if (w_eff1) begin
                w_busy_nxt[bus.waddr1] = 1'b0;
            end else begin
                w_busy_nxt = w_busy_nxt;
            end
            if (bus.iss_valid && !((ZERO_REG != 0) && (bus.iss_rd == {ADDR_W{1'b0}}))) begin
                w_busy_nxt[bus.iss_rd] = 1'b1;
            end else begin
                w_busy_nxt = w_busy_nxt;
            end
        end
    end

    // Scoreboard flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= {DEPTH{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Register array; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_eff0) begin
                r_mem[bus.waddr0] <= bus.wdata0;
            end
            if (w_eff1) begin
                r_mem[bus.waddr1] <= bus.wdata1;
            end
        end
    end
endmodule
